// File: rtl/dec_acc_pkg.sv
// dec_acc_pkg: shared types, key decode and BCD helpers for the decimal key accumulator
package dec_acc_pkg;
  localparam int DIGITS = 10;
  typedef enum logic {IDLE, HELD} state_t;
  typedef struct packed {
    logic       multi;
    logic       any;
    logic [3:0] digit;
  } dec_info_t;
  function automatic dec_info_t onehot_to_digit(input logic [DIGITS-1:0] v);
    dec_info_t r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i]) begin
        r.multi = r.any;
        r.any   = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction
  function automatic int bcd_digits(input int w);
    return (w * 302 + 999) / 1000 + 1;
  endfunction
  function automatic logic [23:0] to_bcd(input logic [15:0] bin);
    logic [23:0] b;
    b = '0;
    for (int i = 15; i >= 0; i--) begin
      for (int d = 0; d < 6; d++) begin
        if (b[4*d+:4] >= 4'd5) b[4*d+:4] = b[4*d+:4] + 4'd3;
      end
      b = {b[22:0], bin[i]};
    end
    return b;
  endfunction
endpackage

// File: rtl/dec_onehot_decode.sv
// dec_onehot_decode: splits a registered one-hot key vector into any/multi flags and a digit
module dec_onehot_decode
  import dec_acc_pkg::*;
(
  input  logic [DIGITS-1:0] dec_q,
  output logic              any,
  output logic              multi,
  output logic [3:0]        digit
);
  dec_info_t info;
  assign info  = onehot_to_digit(dec_q);
  assign any   = info.any;
  assign multi = info.multi;
  assign digit = info.digit;
endmodule

// File: rtl/dec_key_accumulator.sv
// dec_key_accumulator: adds each key press once into Sum; DEC_ACC_BCD_EN adds a registered BCD copy
module dec_key_accumulator
  import dec_acc_pkg::*;
#(
  parameter int SUM_W    = 5,
  parameter int CNT_W    = 4,
  parameter int SAT_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DIGITS-1:0] Dec,
  input  logic              Clr,
  output logic [SUM_W-1:0]  Sum,
  output logic [CNT_W-1:0]  Key_Cnt,
  output logic              Valid,
  output logic              Ovf,
  output logic              Err
`ifdef DEC_ACC_BCD_EN
  ,
  output logic [4*bcd_digits(SUM_W)-1:0] Sum_Bcd
`endif
);
  logic [DIGITS-1:0] dec_q;
  state_t            state, state_n;
  logic              any, multi, accept;
  logic [3:0]        digit;
  logic [SUM_W:0]    add;
  logic [SUM_W-1:0]  sum_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              valid_n, ovf_n, err_n;
  dec_onehot_decode u_decode (
    .dec_q(dec_q),
    .any  (any),
    .multi(multi),
    .digit(digit)
  );
  assign add = {1'b0, Sum} + {{(SUM_W-3){1'b0}}, digit};
  // next state and accumulator update; Clr wins over a press, and a held key keeps us in HELD
  always_comb begin
    accept  = state == IDLE && any && !multi;
    state_n = any ? HELD : IDLE;
    sum_n   = Clr ? '0 : accept ? ((add[SUM_W] && SAT_MODE != 0) ? '1 : add[SUM_W-1:0]) : Sum;
    cnt_n   = Clr ? '0 : (accept && !(&Key_Cnt)) ? Key_Cnt + CNT_W'(1) : Key_Cnt;
    valid_n = !Clr && accept;
    ovf_n   = !Clr && (Ovf || (accept && add[SUM_W]));
    err_n   = !Clr && (Err || (state == IDLE && multi));
  end
  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end
  // input capture and accumulated outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_q   <= '0;
      Sum     <= '0;
      Key_Cnt <= '0;
      Valid   <= 1'b0;
      Ovf     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      dec_q   <= Dec;
      Sum     <= sum_n;
      Key_Cnt <= cnt_n;
      Valid   <= valid_n;
      Ovf     <= ovf_n;
      Err     <= err_n;
    end
  end
`ifdef DEC_ACC_BCD_EN
  localparam int BCD_W = 4 * bcd_digits(SUM_W);
  logic [BCD_W-1:0] bcd_n;
  assign bcd_n = BCD_W'(to_bcd(16'(sum_n)));
  // BCD copy tracks the value Sum takes on the same edge
  always_ff @(posedge CLK) begin
    if (RST) Sum_Bcd <= '0;
    else     Sum_Bcd <= bcd_n;
  end
`endif
endmodule

// File: tb/tb_dec_key_accumulator.sv
// tb_dec_key_accumulator: scoreboard bench driving wrap and saturate instances with the same key stream
module tb_dec_key_accumulator;
  import dec_acc_pkg::*;
  localparam int SW = 5, CW = 4, SMAX = 31, CMAX = 15;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic [9:0] dec = '0;
  logic [SW-1:0] s0, s1;
  logic [CW-1:0] c0, c1;
  logic v0, v1, o0, o1, e0, e1;
`ifdef DEC_ACC_BCD_EN
  logic [4*bcd_digits(SW)-1:0] b0, b1;
`endif
  typedef struct {
    int s0, s1, c;
    bit o0, o1, e;
  } exp_t;
  exp_t q[$];
  int m_s0, m_s1, m_c;
  bit m_o0, m_o1, m_e;
  int checks = 0, errors = 0, nvalid = 0;

  always #5 clk = ~clk;

  dec_key_accumulator #(.SUM_W(SW), .CNT_W(CW), .SAT_MODE(0)) u0 (
    .CLK(clk), .RST(rst), .Dec(dec), .Clr(clr),
    .Sum(s0), .Key_Cnt(c0), .Valid(v0), .Ovf(o0), .Err(e0)
`ifdef DEC_ACC_BCD_EN
    , .Sum_Bcd(b0)
`endif
  );
  dec_key_accumulator #(.SUM_W(SW), .CNT_W(CW), .SAT_MODE(1)) u1 (
    .CLK(clk), .RST(rst), .Dec(dec), .Clr(clr),
    .Sum(s1), .Key_Cnt(c1), .Valid(v1), .Ovf(o1), .Err(e1)
`ifdef DEC_ACC_BCD_EN
    , .Sum_Bcd(b1)
`endif
  );

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic int bcd_of(input int v);
    int r = 0;
    for (int i = 0; v > 0; i++) begin
      r |= (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    m_s0 = 0; m_s1 = 0; m_c = 0; m_o0 = 0; m_o1 = 0; m_e = 0;
  endtask

  task automatic model_press(input int d);
    m_s0 += d;
    if (m_s0 > SMAX) begin m_s0 -= SMAX + 1; m_o0 = 1; end
    if (m_s1 + d > SMAX) begin m_s1 = SMAX; m_o1 = 1; end
    else m_s1 += d;
    if (m_c < CMAX) m_c++;
    q.push_back('{m_s0, m_s1, m_c, m_o0, m_o1, m_e});
  endtask

  task automatic model_key(input logic [9:0] v);
    int d = 0;
    for (int i = 0; i < 10; i++) if (v[i]) d = i;
    if ($countones(v) > 1) m_e = 1;
    else if (v != 0) model_press(d);
  endtask

  task automatic press(input logic [9:0] v, input int hold, input int gap, input logic [9:0] alt);
    model_key(v);
    dec = v;
    for (int i = 0; i < hold; i++) begin
      if (alt != 0 && i == 1) dec = alt;
      step(1);
    end
    dec = '0;
    step(gap);
  endtask

  task automatic check_all(input string t, input int es0, input int es1, input int ec,
                           input int eo0, input int eo1, input int ee);
    chk({t, "_sum_wrap"}, s0, es0);
    chk({t, "_sum_sat"}, s1, es1);
    chk({t, "_cnt"}, c0, ec);
    chk({t, "_cnt_sat_inst"}, c1, ec);
    chk({t, "_ovf_wrap"}, o0, eo0);
    chk({t, "_ovf_sat"}, o1, eo1);
    chk({t, "_err"}, e0, ee);
    chk({t, "_err_sat_inst"}, e1, ee);
  endtask

  task automatic do_reset();
    step(2);
    chk("pending_valid", q.size(), 0);
    q.delete();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    model_zero();
  endtask

  // scoreboard monitor: every Valid pulse consumes one expected snapshot
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (v0 || v1)) begin
      chk("valid_pair", v1, v0);
      nvalid++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got Valid=1 expected no press pending (sum %0d)", s0);
      end else begin
        e = q.pop_front();
        chk("mon_sum_wrap", s0, e.s0);
        chk("mon_sum_sat", s1, e.s1);
        chk("mon_cnt", c0, e.c);
        chk("mon_ovf_wrap", o0, e.o0);
        chk("mon_ovf_sat", o1, e.o1);
        chk("mon_err", e0, e.e);
`ifdef DEC_ACC_BCD_EN
        chk("mon_bcd_wrap", b0, bcd_of(e.s0));
        chk("mon_bcd_sat", b1, bcd_of(e.s1));
`endif
      end
    end
  end

  initial begin
    int nv;
    logic [9:0] v, alt;
    model_zero();
    step(3);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_valid", v0, 0);
    rst = 1'b0;
    step(1);
    // four distinct presses with short gaps
    nv = nvalid;
    press(10'd1 << 3, 4, 1, '0);
    press(10'd1 << 4, 4, 1, '0);
    press(10'd1 << 5, 4, 1, '0);
    press(10'd1 << 6, 4, 1, '0);
    step(2);
    check_all("t1", 18, 18, 4, 0, 0, 0);
    chk("t1_valid_count", nvalid - nv, 4);
    // long hold adds once
    do_reset();
    nv = nvalid;
    press(10'd1 << 7, 20, 1, '0);
    step(2);
    check_all("t2", 7, 7, 1, 0, 0, 0);
    chk("t2_valid_count", nvalid - nv, 1);
    // overflow: wrap vs saturate
    do_reset();
    repeat (4) press(10'd1 << 9, 3, 1, '0);
    step(2);
    check_all("t3", 4, 31, 4, 1, 1, 0);
    press(10'd1 << 2, 3, 1, '0);
    step(2);
    check_all("t3b", 6, 31, 5, 1, 1, 0);
    // multi-hot from IDLE
    do_reset();
    press(10'b0000011000, 3, 1, '0);
    step(2);
    check_all("t4", 0, 0, 0, 0, 0, 1);
    press(10'd1 << 2, 3, 1, '0);
    step(2);
    check_all("t4b", 2, 2, 1, 0, 0, 1);
    // Clr while key held, then no re-add
    do_reset();
    dec = 10'd1 << 5;
    model_key(dec);
    step(4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    model_zero();
    check_all("t5_clr", 0, 0, 0, 0, 0, 0);
    chk("t5_clr_valid", v0, 0);
    step(5);
    chk("t5_held_sum", s0, 0);
    dec = '0;
    step(1);
    press(10'd1 << 1, 3, 1, '0);
    step(2);
    check_all("t5b", 1, 1, 1, 0, 0, 0);
    // reset mid-hold, key still held afterwards counts as a new press
    dec = 10'd1 << 8;
    model_key(dec);
    step(4);
    rst = 1'b1;
    step(2);
    check_all("t5_rst", 0, 0, 0, 0, 0, 0);
    chk("t5_rst_valid", v0, 0);
    q.delete();
    model_zero();
    rst = 1'b0;
    model_key(dec);
    step(4);
    dec = '0;
    step(2);
    check_all("t5c", 8, 8, 1, 0, 0, 0);
    // randomized presses, including multi-hot and changes while held
    do_reset();
    repeat (60) begin
      v = 10'd1 << $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) v |= 10'd1 << $urandom_range(0, 9);
      alt = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : '0;
      press(v, $urandom_range(2, 5), $urandom_range(1, 3), alt);
    end
    step(3);
    chk("rand_drain", q.size(), 0);
    check_all("rand_end", m_s0, m_s1, m_c, m_o0, m_o1, m_e);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
